// File: rtl/axi_ax_snoop_stream_buf.sv
// AXI4 Ax-channel snooper: forwards AR/AW unchanged and queues each handshake
// as a header packet, split into DATA_WIDTH-bit beats on a valid/ready stream.
module axi_ax_snoop_stream_buf #(
    parameter int DATA_WIDTH        = 64,
    parameter int ADDR_WIDTH        = 64,
    parameter int ID_WIDTH          = 32,
    parameter int BURST_LEN         = 8,
    parameter int LOCK_WIDTH        = 2,
    parameter int USER_WIDTH        = 64,
    parameter int STREAM_TYPE_WIDTH = 3,
    parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = '0,
    parameter int DEPTH             = 4,
    parameter int BLOCKING          = 1,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ready,
    output logic                  valid,
    output logic                  in_progress,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] data,
    output logic [CNT_WIDTH-1:0]  drop_count,

    input  logic [ID_WIDTH-1:0]   AXIS_axid,
    input  logic [ADDR_WIDTH-1:0] AXIS_axaddr,
    input  logic [BURST_LEN-1:0]  AXIS_axlen,
    input  logic [2:0]            AXIS_axsize,
    input  logic [1:0]            AXIS_axburst,
    input  logic [LOCK_WIDTH-1:0] AXIS_axlock,
    input  logic [3:0]            AXIS_axcache,
    input  logic [2:0]            AXIS_axprot,
    input  logic [3:0]            AXIS_axregion,
    input  logic [3:0]            AXIS_axqos,
    input  logic [USER_WIDTH-1:0] AXIS_axuser,
    input  logic                  AXIS_axvalid,
    output logic                  AXIS_axready,

    output logic [ID_WIDTH-1:0]   AXIM_axid,
    output logic [ADDR_WIDTH-1:0] AXIM_axaddr,
    output logic [BURST_LEN-1:0]  AXIM_axlen,
    output logic [2:0]            AXIM_axsize,
    output logic [1:0]            AXIM_axburst,
    output logic [LOCK_WIDTH-1:0] AXIM_axlock,
    output logic [3:0]            AXIM_axcache,
    output logic [2:0]            AXIM_axprot,
    output logic [3:0]            AXIM_axregion,
    output logic [3:0]            AXIM_axqos,
    output logic [USER_WIDTH-1:0] AXIM_axuser,
    output logic                  AXIM_axvalid,
    input  logic                  AXIM_axready
);

    localparam int TOP_W  = STREAM_TYPE_WIDTH + ID_WIDTH + BURST_LEN;
    localparam int HDR_W  = TOP_W + ADDR_WIDTH;
    localparam int BEATS  = (HDR_W + DATA_WIDTH - 1) / DATA_WIDTH;
    localparam int WORD_W = BEATS * DATA_WIDTH;
    localparam int ENT_W  = ID_WIDTH + BURST_LEN + ADDR_WIDTH;
    localparam int AW     = $clog2(DEPTH);
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic NONBLK = (BLOCKING == 0);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [AW:0]       wr_q, wr_d, rd_q, rd_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [ENT_W-1:0]  mem_q [DEPTH];
    logic [ENT_W-1:0]  head;
    logic [WORD_W-1:0] word;

    logic full, empty, one_left;
    logic gate, capture, push, drop, pop;

    // Passthrough stays combinational and is never gated while in reset
    assign AXIM_axid     = AXIS_axid;
    assign AXIM_axaddr   = AXIS_axaddr;
    assign AXIM_axlen    = AXIS_axlen;
    assign AXIM_axsize   = AXIS_axsize;
    assign AXIM_axburst  = AXIS_axburst;
    assign AXIM_axlock   = AXIS_axlock;
    assign AXIM_axcache  = AXIS_axcache;
    assign AXIM_axprot   = AXIS_axprot;
    assign AXIM_axregion = AXIS_axregion;
    assign AXIM_axqos    = AXIS_axqos;
    assign AXIM_axuser   = AXIS_axuser;

    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = (wr_q == rd_q);
    assign one_left = ((wr_q - rd_q) == (AW+1)'(1));

    assign gate         = ~resetn | ~full | NONBLK;
    assign AXIM_axvalid = AXIS_axvalid & gate;
    assign AXIS_axready = AXIM_axready & gate;

    assign capture = resetn & AXIS_axvalid & AXIM_axready & gate;
    assign push    = capture & ~full;
    assign drop    = capture & full;

    assign valid       = (state_q == SEND);
    assign in_progress = valid;
    assign last        = valid & (beat_q == LAST_BEAT);
    assign pop         = last & ready;

    assign head = mem_q[rd_q[AW-1:0]];

    always_comb begin
        word = '0;
        word[ADDR_WIDTH-1:0] = head[ADDR_WIDTH-1:0];
        word[WORD_W-1 -: TOP_W] = {STREAM_TYPE, head[ENT_W-1:ADDR_WIDTH]};
        data = '0;
        // Beat 0 carries the most significant slice
        for (int b = 0; b < BEATS; b++) begin
            if (valid && beat_q == BW'(b)) begin
                data = word[(BEATS-1-b)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        unique case (state_q)
            IDLE: begin
                if (!empty || push) begin
                    state_d = SEND;
                    beat_d  = '0;
                end
            end
            SEND: begin
                if (ready) begin
                    if (beat_q == LAST_BEAT) begin
                        beat_d  = '0;
                        state_d = (!one_left || push) ? SEND : IDLE;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_d  = wr_q + (AW+1)'(push);
        rd_d  = rd_q + (AW+1)'(pop);
        cnt_d = cnt_q;
        if (drop && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is flushed through the pointers, so it needs no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q[AW-1:0]] <= {AXIS_axid, AXIS_axlen, AXIS_axaddr};
        end
    end

    assign drop_count = cnt_q;

endmodule

// File: tb/tb_axi_ax_snoop_stream_buf.sv
// Directed bench: three instances (128-bit, 64-bit blocking, 64-bit dropping)
// driven one at a time from a shared set of Ax field signals.
module tb_axi_ax_snoop_stream_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        mready;
    logic [31:0] id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [1:0]  lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  region;
    logic [3:0]  qos;
    logic [63:0] user;

    logic av_a, av_b, av_c;
    logic rdy_a, rdy_b, rdy_c;
    logic sr_a, sr_b, sr_c;
    logic mv_a, mv_b, mv_c;
    logic val_a, val_b, val_c;
    logic ip_a, ip_b, ip_c;
    logic last_a, last_b, last_c;
    logic [127:0] data_a;
    logic [63:0]  data_b, data_c;
    logic [15:0]  drop_a, drop_b;
    logic [2:0]   drop_c;

    logic [31:0] mid_a, mid_b, mid_c;
    logic [63:0] maddr_a, maddr_b, maddr_c;
    logic [7:0]  mlen_a, mlen_b, mlen_c;
    logic [2:0]  msize_a, msize_b, msize_c;
    logic [1:0]  mburst_a, mburst_b, mburst_c;
    logic [1:0]  mlock_a, mlock_b, mlock_c;
    logic [3:0]  mcache_a, mcache_b, mcache_c;
    logic [2:0]  mprot_a, mprot_b, mprot_c;
    logic [3:0]  mreg_a, mreg_b, mreg_c;
    logic [3:0]  mqos_a, mqos_b, mqos_c;
    logic [63:0] muser_a, muser_b, muser_c;

    axi_ax_snoop_stream_buf #(.DATA_WIDTH(128)) u_a (
        .clk(clk), .resetn(resetn), .ready(rdy_a), .valid(val_a),
        .in_progress(ip_a), .last(last_a), .data(data_a), .drop_count(drop_a),
        .AXIS_axid(id), .AXIS_axaddr(addr), .AXIS_axlen(len),
        .AXIS_axsize(size), .AXIS_axburst(burst), .AXIS_axlock(lock),
        .AXIS_axcache(cache), .AXIS_axprot(prot), .AXIS_axregion(region),
        .AXIS_axqos(qos), .AXIS_axuser(user),
        .AXIS_axvalid(av_a), .AXIS_axready(sr_a),
        .AXIM_axid(mid_a), .AXIM_axaddr(maddr_a), .AXIM_axlen(mlen_a),
        .AXIM_axsize(msize_a), .AXIM_axburst(mburst_a), .AXIM_axlock(mlock_a),
        .AXIM_axcache(mcache_a), .AXIM_axprot(mprot_a), .AXIM_axregion(mreg_a),
        .AXIM_axqos(mqos_a), .AXIM_axuser(muser_a),
        .AXIM_axvalid(mv_a), .AXIM_axready(mready)
    );

    axi_ax_snoop_stream_buf #(.DATA_WIDTH(64), .DEPTH(4), .BLOCKING(1)) u_b (
        .clk(clk), .resetn(resetn), .ready(rdy_b), .valid(val_b),
        .in_progress(ip_b), .last(last_b), .data(data_b), .drop_count(drop_b),
        .AXIS_axid(id), .AXIS_axaddr(addr), .AXIS_axlen(len),
        .AXIS_axsize(size), .AXIS_axburst(burst), .AXIS_axlock(lock),
        .AXIS_axcache(cache), .AXIS_axprot(prot), .AXIS_axregion(region),
        .AXIS_axqos(qos), .AXIS_axuser(user),
        .AXIS_axvalid(av_b), .AXIS_axready(sr_b),
        .AXIM_axid(mid_b), .AXIM_axaddr(maddr_b), .AXIM_axlen(mlen_b),
        .AXIM_axsize(msize_b), .AXIM_axburst(mburst_b), .AXIM_axlock(mlock_b),
        .AXIM_axcache(mcache_b), .AXIM_axprot(mprot_b), .AXIM_axregion(mreg_b),
        .AXIM_axqos(mqos_b), .AXIM_axuser(muser_b),
        .AXIM_axvalid(mv_b), .AXIM_axready(mready)
    );

    axi_ax_snoop_stream_buf #(
        .DATA_WIDTH(64), .DEPTH(2), .BLOCKING(0), .CNT_WIDTH(3)
    ) u_c (
        .clk(clk), .resetn(resetn), .ready(rdy_c), .valid(val_c),
        .in_progress(ip_c), .last(last_c), .data(data_c), .drop_count(drop_c),
        .AXIS_axid(id), .AXIS_axaddr(addr), .AXIS_axlen(len),
        .AXIS_axsize(size), .AXIS_axburst(burst), .AXIS_axlock(lock),
        .AXIS_axcache(cache), .AXIS_axprot(prot), .AXIS_axregion(region),
        .AXIS_axqos(qos), .AXIS_axuser(user),
        .AXIS_axvalid(av_c), .AXIS_axready(sr_c),
        .AXIM_axid(mid_c), .AXIM_axaddr(maddr_c), .AXIM_axlen(mlen_c),
        .AXIM_axsize(msize_c), .AXIM_axburst(mburst_c), .AXIM_axlock(mlock_c),
        .AXIM_axcache(mcache_c), .AXIM_axprot(mprot_c), .AXIM_axregion(mreg_c),
        .AXIM_axqos(mqos_c), .AXIM_axuser(muser_c),
        .AXIM_axvalid(mv_c), .AXIM_axready(mready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] hdr(input logic [31:0] i,
                                         input logic [7:0] l,
                                         input logic [63:0] a);
        return {3'b000, i, l, 21'b0, a};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ax(input int i, input int l, input logic [63:0] a);
        id   = 32'(i);
        len  = 8'(l);
        addr = a;
    endtask

    logic [127:0] w;
    int acc;
    int beats;
    int n;

    initial begin
        resetn = 1'b0; mready = 1'b1;
        id = '0; addr = '0; len = '0; size = 3'd3; burst = 2'd1;
        lock = '0; cache = 4'h3; prot = '0; region = '0; qos = '0;
        user = 64'hCAFE;
        av_a = 0; av_b = 0; av_c = 0;
        rdy_a = 0; rdy_b = 0; rdy_c = 0;

        // Reset state and live passthrough while in reset
        repeat (2) cyc();
        ax(1, 0, 64'h40); av_a = 1;
        @(negedge clk);
        chk("rst_valid", val_a, 0);
        chk("rst_inprog", ip_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_drop", drop_c, 0);
        chk("rst_pass_mv", mv_a, 1);
        chk("rst_pass_sr", sr_a, 1);
        cyc();
        av_a = 0; resetn = 1;
        cyc();
        @(negedge clk);
        chk("rst_nocap", val_a, 0);

        // Single AW through the 128-bit instance
        cyc();
        ax(5, 7, 64'h1000); av_a = 1; rdy_a = 1;
        @(negedge clk);
        chk("t1_sready", sr_a, 1);
        chk("t1_maddr", maddr_a, 64'h1000);
        chk("t1_muser", muser_a, 64'hCAFE);
        chk("t1_pre_valid", val_a, 0);
        cyc();
        av_a = 0;
        @(negedge clk);
        chk("t1_valid", val_a, 1);
        chk("t1_last", last_a, 1);
        chk("t1_inprog", ip_a, 1);
        chk("t1_data", data_a, hdr(5, 7, 64'h1000));
        cyc();
        @(negedge clk);
        chk("t1_idle", val_a, 0);

        // Back-to-back AWs: push and pop in the same cycle, no bubble
        for (int i = 0; i < 3; i++) begin
            cyc();
            ax(10 + i, i, 64'h2000 + 64'(i)); av_a = 1;
            @(negedge clk);
            if (i == 0) chk("t6_v0", val_a, 0);
            else begin
                chk("t6_valid", val_a, 1);
                chk("t6_data", data_a, hdr(32'(9 + i), 8'(i - 1),
                                            64'h2000 + 64'(i - 1)));
            end
        end
        cyc();
        av_a = 0;
        @(negedge clk);
        chk("t6_valid3", val_a, 1);
        chk("t6_data3", data_a, hdr(12, 2, 64'h2002));
        cyc();
        @(negedge clk);
        chk("t6_idle", val_a, 0);

        // Two-beat packet with back-pressure on the final beat
        cyc();
        ax(5, 7, 64'h1000); av_b = 1; rdy_b = 1;
        @(negedge clk);
        chk("t2_sready", sr_b, 1);
        cyc();
        av_b = 0;
        w = hdr(5, 7, 64'h1000);
        @(negedge clk);
        chk("t2_b0_valid", val_b, 1);
        chk("t2_b0_last", last_b, 0);
        chk("t2_b0_data", data_b, w[127:64]);
        cyc();
        rdy_b = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", val_b, 1);
            chk("t2_hold_last", last_b, 1);
            chk("t2_hold_data", data_b, 64'h1000);
            cyc();
        end
        rdy_b = 1;
        @(negedge clk);
        chk("t2_b1_last", last_b, 1);
        cyc();
        @(negedge clk);
        chk("t2_idle", val_b, 0);

        // Blocking: six ARs with stream stalled, only four fit
        cyc();
        rdy_b = 0; acc = 0;
        for (int k = 0; k < 6; k++) begin
            ax(acc + 1, acc, 64'h100 * 64'(acc + 1)); av_b = 1;
            @(negedge clk);
            chk("t3_sready", sr_b, (acc < 4) ? 1 : 0);
            chk("t3_mvalid", mv_b, (acc < 4) ? 1 : 0);
            if (sr_b) acc++;
            cyc();
        end
        chk("t3_accepted", acc, 4);
        chk("t3_valid_stall", val_b, 1);
        rdy_b = 1; beats = 0;
        for (int k = 0; k < 60 && beats < 12; k++) begin
            if (acc < 6) begin
                ax(acc + 1, acc, 64'h100 * 64'(acc + 1)); av_b = 1;
            end else av_b = 0;
            @(negedge clk);
            if (av_b && sr_b) acc++;
            if (val_b) begin
                n = beats / 2;
                w = hdr(32'(n + 1), 8'(n), 64'h100 * 64'(n + 1));
                if (beats % 2 == 0) chk("t3_data", data_b, w[127:64]);
                else chk("t3_data", data_b, w[63:0]);
                chk("t3_last", last_b, (beats % 2 == 1) ? 1 : 0);
                beats++;
            end
            cyc();
        end
        av_b = 0;
        chk("t3_beats", beats, 12);
        chk("t3_accepted_all", acc, 6);
        @(negedge clk);
        chk("t3_idle", val_b, 0);

        // Non-blocking: everything passes, overflow headers counted
        cyc();
        rdy_c = 0;
        for (int i = 1; i <= 5; i++) begin
            ax(i, 0, 64'h100 * 64'(i)); av_c = 1;
            @(negedge clk);
            chk("t4_sready", sr_c, 1);
            chk("t4_mvalid", mv_c, 1);
            cyc();
        end
        av_c = 0;
        @(negedge clk);
        chk("t4_drop3", drop_c, 3);
        for (int i = 6; i <= 11; i++) begin
            cyc();
            ax(i, 0, 64'h100 * 64'(i)); av_c = 1;
        end
        cyc();
        av_c = 0;
        @(negedge clk);
        chk("t4_drop_sat", drop_c, 7);
        cyc();
        rdy_c = 1; beats = 0;
        for (int k = 0; k < 20 && beats < 4; k++) begin
            @(negedge clk);
            if (val_c) begin
                n = beats / 2;
                w = hdr(32'(n + 1), 8'd0, 64'h100 * 64'(n + 1));
                if (beats % 2 == 0) chk("t4_data", data_c, w[127:64]);
                else chk("t4_data", data_c, w[63:0]);
                beats++;
            end
            cyc();
        end
        chk("t4_beats", beats, 4);
        @(negedge clk);
        chk("t4_idle", val_c, 0);

        // Reset between beat 0 and beat 1
        cyc();
        ax(9, 1, 64'h3000); av_b = 1; rdy_b = 1;
        @(negedge clk);
        cyc();
        av_b = 0;
        @(negedge clk);
        chk("t5_b0_valid", val_b, 1);
        chk("t5_b0_last", last_b, 0);
        cyc();
        rdy_b = 0; resetn = 0;
        ax(32'h77, 0, 64'h4000); av_b = 1;
        @(negedge clk);
        chk("t5_rst_sr", sr_b, 1);
        chk("t5_rst_mv", mv_b, 1);
        cyc();
        av_b = 0;
        @(negedge clk);
        chk("t5_valid", val_b, 0);
        chk("t5_inprog", ip_b, 0);
        chk("t5_last", last_b, 0);
        chk("t5_data", data_b, 0);
        chk("t5_drop", drop_c, 0);
        cyc();
        resetn = 1; rdy_b = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_empty", val_b, 0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
